// File: rtl/fpga_prog_pkg.sv
// rtl/fpga_prog_pkg.sv - shared state type, error codes, header layout and chain length helper
package fpga_prog_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_SYNC  = 3'd1;
  localparam logic [2:0] ERR_CHAIN = 3'd2;
  localparam logic [2:0] ERR_LEN   = 3'd3;
  localparam logic [2:0] ERR_CSUM  = 3'd4;

  // Header word: {sync, len, chain}; sync occupies everything above bit 23.
  localparam int HDR_SYNC_LSB  = 24;
  localparam int HDR_LEN_MSB   = 23;
  localparam int HDR_LEN_LSB   = 8;
  localparam int HDR_CHAIN_MSB = 7;
  localparam int HDR_CHAIN_LSB = 0;

  localparam logic [7:0] SYNC = 8'hA5;

  // Even chains are crossbar lines (2V+1 words), odd chains carry one extra
  // word for the input-logic stage (2V+2 words).
  function automatic logic [15:0] chain_len(input int idx, input int v);
    if (idx % 2 == 1) return 16'(2 * v + 2);
    else              return 16'(2 * v + 1);
  endfunction

endpackage

// File: rtl/fpga_prog_hdr_dec.sv
// rtl/fpga_prog_hdr_dec.sv - combinational header field extraction and validation
module fpga_prog_hdr_dec
  import fpga_prog_pkg::*;
#(
  parameter int H = 2,
  parameter int V = 4,
  parameter int W = 32
) (
  input  logic [W-1:0]                 hdr_i,
  output logic [$clog2(2*H+1)-1:0]     chain_o,
  output logic [15:0]                  len_o,
  output logic [2:0]                   err_code_o
);

  localparam int CW = $clog2(2 * H + 1);

  logic [W-HDR_SYNC_LSB-1:0] sync;
  logic [7:0]                chain_raw;

  assign sync      = hdr_i[W-1:HDR_SYNC_LSB];
  assign len_o     = hdr_i[HDR_LEN_MSB:HDR_LEN_LSB];
  assign chain_raw = hdr_i[HDR_CHAIN_MSB:HDR_CHAIN_LSB];
  // Only meaningful when err_code_o is ERR_NONE (range already checked).
  assign chain_o   = chain_raw[CW-1:0];

  // Checks in priority order: sync word, chain range, then length for that chain.
  always_comb begin
    err_code_o = ERR_NONE;
    if (sync != (W-HDR_SYNC_LSB)'(SYNC)) begin
      err_code_o = ERR_SYNC;
    end else if (int'(chain_raw) > 2 * H) begin
      err_code_o = ERR_CHAIN;
    end else if (len_o != chain_len(int'(chain_raw), V)) begin
      err_code_o = ERR_LEN;
    end
  end

endmodule

// File: rtl/fpga_prog_loader.sv
// rtl/fpga_prog_loader.sv - packetised configuration loader driving per-chain shift enables
module fpga_prog_loader
  import fpga_prog_pkg::*;
#(
  parameter int H = 2,
  parameter int V = 4,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           res,
  input  logic           clr,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   prog_o,
  output logic [2*H:0]   prog_shft,
  output logic           busy,
  output logic           cfg_done,
  output logic           fab_en,
  output logic           err,
  output logic [2:0]     err_code
);

  localparam int NCH = 2 * H + 1;
  localparam int CW  = $clog2(NCH);

  state_e          state_q, state_d;
  logic [CW-1:0]   chain_q, chain_d, hdr_chain;
  logic [15:0]     cnt_q, cnt_d, hdr_len;
  logic [W-1:0]    sum_q, sum_d, prog_q, prog_d;
  logic [NCH-1:0]  ok_q, ok_d, shft_q, shft_d;
  logic [2:0]      code_q, code_d, hdr_code;
  logic            done_q, fab_q;
  logic            accept;

  fpga_prog_hdr_dec #(.H(H), .V(V), .W(W)) u_hdr_dec (
    .hdr_i      (in_data),
    .chain_o    (hdr_chain),
    .len_o      (hdr_len),
    .err_code_o (hdr_code)
  );

  // Reset also holds ready low so nothing looks accepted while the loader is held.
  assign in_ready  = (state_q != ERR) & ~clr & ~res;
  assign accept    = in_valid & in_ready;

  assign prog_o    = prog_q;
  assign prog_shft = shft_q;
  assign busy      = (state_q == LOAD) | (state_q == CHK);
  assign cfg_done  = done_q;
  assign fab_en    = fab_q;
  assign err       = (state_q == ERR);
  assign err_code  = code_q;

  // Packet FSM: header check, payload shifting with running checksum, trailer compare.
  always_comb begin
    state_d = state_q;
    chain_d = chain_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    prog_d  = prog_q;
    ok_d    = ok_q;
    shft_d  = '0;
    code_d  = code_q;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      sum_d   = '0;
      ok_d    = '0;
      code_d  = ERR_NONE;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (hdr_code != ERR_NONE) begin
            state_d = ERR;
            code_d  = hdr_code;
          end else begin
            // A reloaded chain is untrusted until its trailer verifies again.
            chain_d         = hdr_chain;
            cnt_d           = hdr_len;
            sum_d           = '0;
            ok_d[hdr_chain] = 1'b0;
            state_d         = LOAD;
          end
        end
        LOAD: begin
          prog_d = in_data;
          shft_d = NCH'(1) << chain_q;
          sum_d  = sum_q + in_data;
          cnt_d  = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = CHK;
        end
        CHK: begin
          if (in_data == sum_q) begin
            ok_d[chain_q] = 1'b1;
            state_d       = IDLE;
          end else begin
            state_d = ERR;
            code_d  = ERR_CSUM;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers; done/fab follow next-state so they move with the accept.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      chain_q <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      prog_q  <= '0;
      ok_q    <= '0;
      shft_q  <= '0;
      code_q  <= ERR_NONE;
      done_q  <= 1'b0;
      fab_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      prog_q  <= prog_d;
      ok_q    <= ok_d;
      shft_q  <= shft_d;
      code_q  <= code_d;
      done_q  <= &ok_d;
      fab_q   <= (&ok_d) & (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_fpga_prog_loader.sv
// tb/tb_fpga_prog_loader.sv - randomized self-checking bench with packet-level reference model
module tb_fpga_prog_loader;

  localparam int H   = 1;
  localparam int V   = 1;
  localparam int W   = 32;
  localparam int NCH = 2 * H + 1;

  logic           clk = 1'b0;
  logic           res, clr, in_valid, in_ready;
  logic [W-1:0]   in_data, prog_o;
  logic [NCH-1:0] prog_shft;
  logic           busy, cfg_done, fab_en, err;
  logic [2:0]     err_code;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt = 0;

  // Reference model in packet terms: words still owed for the current packet.
  int             m_left;   // -1 awaiting header, >0 payload owed, 0 awaiting trailer
  bit             m_err;
  int             m_code;
  int             m_chain;
  logic [31:0]    m_sum;
  logic [NCH-1:0] m_ok;
  logic [31:0]    m_prog;
  logic [NCH-1:0] m_shft;
  bit             m_busy, m_done, m_fab;

  always #5 clk = ~clk;

  fpga_prog_loader #(.H(H), .V(V), .W(W)) dut (
    .clk       (clk),
    .res       (res),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prog_o    (prog_o),
    .prog_shft (prog_shft),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .fab_en    (fab_en),
    .err       (err),
    .err_code  (err_code)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_len(input int ch);
    return (ch % 2 == 1) ? 2 * V + 2 : 2 * V + 1;
  endfunction

  task automatic model_reset();
    m_left = -1; m_err = 1'b0; m_code = 0; m_chain = 0; m_sum = '0;
    m_ok = '0; m_prog = '0; m_shft = '0; m_busy = 1'b0; m_done = 1'b0; m_fab = 1'b0;
  endtask

  task automatic model(input bit acc, input logic [31:0] d, input bit c);
    int ch, len;
    m_shft = '0;
    if (c) begin
      m_left = -1; m_err = 1'b0; m_code = 0; m_ok = '0;
    end else if (acc) begin
      if (m_left < 0) begin
        ch  = int'(d[7:0]);
        len = int'(d[23:8]);
        if (d[31:24] != 8'hA5)      begin m_err = 1'b1; m_code = 1; end
        else if (ch > 2 * H)        begin m_err = 1'b1; m_code = 2; end
        else if (len != exp_len(ch)) begin m_err = 1'b1; m_code = 3; end
        else begin
          m_chain = ch; m_left = len; m_sum = '0; m_ok[ch] = 1'b0;
        end
      end else if (m_left > 0) begin
        m_prog = d;
        m_shft = NCH'(1 << m_chain);
        m_sum  = m_sum + d;
        m_left--;
      end else if (d == m_sum) begin
        m_ok[m_chain] = 1'b1;
        m_left = -1;
      end else begin
        m_err = 1'b1; m_code = 4;
      end
    end
    m_done = &m_ok;
    m_busy = !m_err && (m_left >= 0);
    m_fab  = m_done && !m_err && (m_left < 0);
  endtask

  // One clock: drive at negedge, check ready, then check registered outputs after the edge.
  task automatic step(input bit v, input logic [31:0] d, input bit c);
    bit rdy;
    @(negedge clk);
    in_valid = v; in_data = d; clr = c;
    #1;
    rdy = !m_err && !c;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    @(posedge clk);
    #1;
    model(v && rdy, d, c);
    chk("prog_shft", 32'(prog_shft), 32'(m_shft));
    chk("prog_o", prog_o, m_prog);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("cfg_done", 32'(cfg_done), 32'(m_done));
    chk("fab_en", 32'(fab_en), 32'(m_fab));
    chk("err", 32'(err), 32'(m_err));
    chk("err_code", 32'(err_code), m_code);
    if (prog_shft[1]) pulse_cnt++;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++)
      if ($urandom_range(0, 99) < gap) step(1'b0, $urandom, 1'b0);
    step(1'b1, w, 1'b0);
  endtask

  task automatic send_pkt(input int ch, input int gap, input bit bad_trl);
    logic [31:0] s, w;
    int len;
    len = exp_len(ch);
    s = '0;
    send_word({8'hA5, 16'(len), 8'(ch)}, gap);
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      s = s + w;
      send_word(w, gap);
    end
    send_word(bad_trl ? s + 32'd1 : s, gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_data = $urandom; clr = 1'b0; res = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_prog_o", prog_o, 0);
    chk("rst_prog_shft", 32'(prog_shft), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cfg_done", 32'(cfg_done), 0);
    chk("rst_fab_en", 32'(fab_en), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_code", 32'(err_code), 0);
    model_reset();
    @(negedge clk);
    res = 1'b0; in_valid = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 1);
    chk("rel_cfg_done", 32'(cfg_done), 0);
    chk("rel_fab_en", 32'(fab_en), 0);
  endtask

  task automatic err_case(input string tag, input logic [31:0] hdr, input int code);
    step(1'b1, hdr, 1'b0);
    chk({tag, "_err"}, 32'(err), 1);
    chk({tag, "_code"}, 32'(err_code), code);
    step(1'b1, $urandom, 1'b0);
    step(1'b1, 32'hA5000300, 1'b0);
    chk({tag, "_held"}, 32'(err_code), code);
    step(1'b0, '0, 1'b1);
    chk({tag, "_clr"}, 32'(err), 0);
  endtask

  logic [31:0] s, w;
  int r;

  initial begin
    res = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    res = 1'b0;
    step(1'b0, '0, 1'b0);

    // Single chain 0 packet.
    step(1'b1, 32'hA5000300, 1'b0);
    step(1'b1, 32'd1, 1'b0);
    chk("c0_shft1", 32'(prog_shft), 32'h1);
    step(1'b1, 32'd2, 1'b0);
    step(1'b1, 32'd3, 1'b0);
    chk("c0_prog3", prog_o, 32'd3);
    step(1'b1, 32'd6, 1'b0);
    chk("c0_busy_low", 32'(busy), 0);
    chk("c0_fab_partial", 32'(fab_en), 0);

    // Complete the mask, then reload chain 1 with valid toggling.
    send_pkt(1, 0, 1'b0);
    send_pkt(2, 0, 1'b0);
    chk("all_cfg_done", 32'(cfg_done), 1);
    chk("all_fab_en", 32'(fab_en), 1);
    step(1'b1, 32'hA5000401, 1'b0);
    chk("reload_fab_drop", 32'(fab_en), 0);
    chk("reload_cfg_drop", 32'(cfg_done), 0);
    pulse_cnt = 0;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, $urandom, 1'b0);
      w = $urandom;
      s = s + w;
      step(1'b1, w, 1'b0);
    end
    step(1'b0, '0, 1'b0);
    chk("toggle_pulses", pulse_cnt, 4);
    step(1'b1, s, 1'b0);
    chk("reload_cfg_done", 32'(cfg_done), 1);

    // Error codes.
    err_case("bad_sync", 32'h5A000300, 1);
    err_case("bad_chain", 32'hA5000303, 2);
    err_case("bad_len", 32'hA5000400, 3);
    step(1'b1, 32'hA5000300, 1'b0);
    step(1'b1, 32'd1, 1'b0);
    step(1'b1, 32'd2, 1'b0);
    step(1'b1, 32'd3, 1'b0);
    step(1'b1, 32'd7, 1'b0);
    chk("bad_csum_code", 32'(err_code), 4);
    step(1'b0, '0, 1'b1);

    // clr wins over a header offered in the same cycle and clears the mask.
    send_pkt(0, 0, 1'b0);
    send_pkt(1, 0, 1'b0);
    send_pkt(2, 0, 1'b0);
    step(1'b1, 32'hA5000300, 1'b1);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_err", 32'(err), 0);
    chk("clr_cfg_done", 32'(cfg_done), 0);

    // Reset in the middle of a packet.
    step(1'b1, 32'hA5000300, 1'b0);
    step(1'b1, 32'd9, 1'b0);
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      send_word($urandom, 20);
      else if (r == 1) send_word({8'hA5, 16'($urandom_range(0, 5)), 8'($urandom_range(0, 4))}, 20);
      else             send_pkt($urandom_range(0, 2), 30, r == 2);
      if (m_err || $urandom_range(0, 15) == 0) step(1'($urandom_range(0, 1)), $urandom, 1'b1);
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
